// File: rtl/vga_pic_move_ctrl_pkg.sv
// Shared constants for the bouncing-picture controller: screen/picture geometry,
// RGB565 colours and the per-axis direction encoding.
package vga_pic_move_ctrl_pkg;

    localparam int H_VALID_DEF = 640;
    localparam int V_VALID_DEF = 480;
    localparam int PIC_W_DEF   = 100;
    localparam int PIC_H_DEF   = 100;

    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_BLACK = 16'h0000;

    typedef enum logic {
        FWD = 1'b0,
        REV = 1'b1
    } dir_t;

endpackage

// File: rtl/vga_pic_move_ctrl_axis.sv
// One bounce axis: walks the picture edge between 0 and LIMIT-SIZE, one step per
// enabled frame, reversing direction when the next step would leave the screen.
module pic_bounce_axis
    import vga_pic_move_ctrl_pkg::*;
#(
    parameter int SIZE  = 100,
    parameter int LIMIT = 640,
    parameter int STEP  = 1,
    parameter int INIT  = 270
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       step_en,
    output logic [9:0] pos,
    output dir_t       dir
);

    // 11-bit intermediates so pos+SIZE+STEP cannot wrap
    logic [10:0] pos_ext;
    logic        fwd_hit;
    logic        rev_hit;

    assign pos_ext = {1'b0, pos};
    assign fwd_hit = (pos_ext + 11'(SIZE + STEP)) > 11'(LIMIT);
    assign rev_hit = pos_ext < 11'(STEP);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pos <= 10'(INIT);
            dir <= FWD;
        end else if (step_en) begin
            case (dir)
                FWD: begin
                    if (fwd_hit) begin
                        dir <= REV;
                        pos <= pos - 10'(STEP);
                    end else begin
                        pos <= pos + 10'(STEP);
                    end
                end
                REV: begin
                    if (rev_hit) begin
                        dir <= FWD;
                        pos <= pos + 10'(STEP);
                    end else begin
                        pos <= pos - 10'(STEP);
                    end
                end
                default: dir <= FWD;
            endcase
        end
    end

endmodule

// File: rtl/vga_pic_move_ctrl.sv
// Picture ROM read scheduler and compositor: raster-order ROM addressing for the
// moving picture window, background fill elsewhere, and the per-frame bounce.
module vga_pic_move_ctrl
    import vga_pic_move_ctrl_pkg::*;
#(
    parameter int          H_VALID  = H_VALID_DEF,
    parameter int          V_VALID  = V_VALID_DEF,
    parameter int          PIC_W    = PIC_W_DEF,
    parameter int          PIC_H    = PIC_H_DEF,
    parameter int          STEP     = 1,
    parameter int          ADDR_W   = 14,
    parameter logic [15:0] BG_COLOR = RGB565_WHITE
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              pix_req,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              frame_start,
    input  logic              move_en,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       pix_data,
    output logic [9:0]        pic_x,
    output logic [9:0]        pic_y
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIC_W * PIC_H - 1);

    logic              step_en;
    logic              in_pic;
    logic              req_d;
    logic              pic_d;
    logic [ADDR_W-1:0] addr_cnt;
    logic [10:0]       x_ext, y_ext, px_ext, py_ext;
    dir_t              dir_x, dir_y;
    logic [1:0]        dirs_unused;

    assign step_en = frame_start && move_en;

    pic_bounce_axis #(
        .SIZE (PIC_W),
        .LIMIT(H_VALID),
        .STEP (STEP),
        .INIT ((H_VALID - PIC_W) / 2)
    ) u_axis_x (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .step_en(step_en),
        .pos    (pic_x),
        .dir    (dir_x)
    );

    pic_bounce_axis #(
        .SIZE (PIC_H),
        .LIMIT(V_VALID),
        .STEP (STEP),
        .INIT ((V_VALID - PIC_H) / 2)
    ) u_axis_y (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .step_en(step_en),
        .pos    (pic_y),
        .dir    (dir_y)
    );

    // Directions are internal state only; kept as named nets for debug visibility
    assign dirs_unused = {dir_x, dir_y};

    assign x_ext  = {1'b0, pix_x};
    assign y_ext  = {1'b0, pix_y};
    assign px_ext = {1'b0, pic_x};
    assign py_ext = {1'b0, pic_y};

    assign in_pic = pix_req
                 && (x_ext >= px_ext) && (x_ext < px_ext + 11'(PIC_W))
                 && (y_ext >= py_ext) && (y_ext < py_ext + 11'(PIC_H));

    assign rom_rd_en = in_pic;
    assign rom_addr  = addr_cnt;

    // Address follows raster order only; frame_start beats a coincident read
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            addr_cnt <= '0;
            req_d    <= 1'b0;
            pic_d    <= 1'b0;
        end else begin
            req_d <= pix_req;
            pic_d <= in_pic;
            if (frame_start) begin
                addr_cnt <= '0;
            end else if (in_pic) begin
                addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
            end
        end
    end

    assign pix_data = pic_d ? rom_data : (req_d ? BG_COLOR : RGB565_BLACK);

endmodule

// File: tb/tb_vga_pic_move_ctrl.sv
// Scoreboard bench for vga_pic_move_ctrl: stimulus queues expected ROM addresses
// and pixels, a negedge monitor pops and compares them as the DUT presents them.
module tb_vga_pic_move_ctrl;
    import vga_pic_move_ctrl_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        pix_req = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        frame_start = 1'b0;
    logic        move_en = 1'b0;
    logic        rom_rd_en;
    logic [13:0] rom_addr;
    logic [15:0] rom_data = '0;
    logic [15:0] pix_data;
    logic [9:0]  pic_x, pic_y;

    vga_pic_move_ctrl dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .pix_req    (pix_req),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_start(frame_start),
        .move_en    (move_en),
        .rom_rd_en  (rom_rd_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_data   (pix_data),
        .pic_x      (pic_x),
        .pic_y      (pic_y)
    );

    always #5 sys_clk = ~sys_clk;

    // ROM model: registered output, content equals its own address
    always @(posedge sys_clk) if (rom_rd_en) rom_data <= {2'b00, rom_addr};

    int n_checks = 0;
    int n_pass = 0;
    int rd_count = 0;
    int exp_addr = 0;
    int mpx = 270;
    int mpy = 190;
    logic [13:0] addr_q[$];
    logic [15:0] pix_q[$];
    logic prev_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    always @(negedge sys_clk) begin
        if (prev_req) begin
            if (pix_q.size() == 0) check("pix_unexpected", {16'h0, pix_data}, 32'hFFFF_FFFF);
            else check("pix_data", {16'h0, pix_data}, {16'h0, pix_q.pop_front()});
        end
        if (rom_rd_en) begin
            rd_count++;
            if (addr_q.size() == 0) check("rd_unexpected", {18'h0, rom_addr}, 32'hFFFF_FFFF);
            else check("rom_addr", {18'h0, rom_addr}, {18'h0, addr_q.pop_front()});
        end
        prev_req = pix_req && !sys_rst;
    end

    task automatic req(input int x, input int y, input logic fs);
        logic inp;
        @(posedge sys_clk); #1;
        pix_req = 1'b1; pix_x = 10'(x); pix_y = 10'(y); frame_start = fs;
        inp = (x >= mpx) && (x < mpx + 100) && (y >= mpy) && (y < mpy + 100);
        if (inp) begin
            addr_q.push_back(14'(exp_addr));
            pix_q.push_back(16'(exp_addr));
        end else begin
            pix_q.push_back(16'hFFFF);
        end
        if (fs) exp_addr = 0;
        else if (inp) exp_addr = (exp_addr == 9999) ? 0 : exp_addr + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk); #1;
            pix_req = 1'b0; frame_start = 1'b0;
        end
    endtask

    task automatic fs_pulse();
        @(posedge sys_clk); #1;
        pix_req = 1'b0; frame_start = 1'b1;
        exp_addr = 0;
        @(posedge sys_clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic scan_window(input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = 268; x <= 371; x++)
                req(x, y, 1'b0);
        idle(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int rd0;
        // reset values
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_pic_x", pic_x, 270);
        check("rst_pic_y", pic_y, 190);
        check("rst_rd_en", rom_rd_en, 0);
        check("rst_pix_data", pix_data, 0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        // full picture window, move_en low: exactly 10000 reads, addr 0..9999
        fs_pulse();
        rd0 = rd_count;
        scan_window(190, 289);
        check("frame_rd_count", rd_count - rd0, 10000);
        check("addr_wrapped_after_frame", rom_addr, 0);
        check("idle_pix_zero", pix_data, 0);

        // frame_start colliding with an in-picture read
        fs_pulse();
        req(270, 190, 1'b0);
        req(271, 190, 1'b0);
        req(272, 190, 1'b0);
        req(273, 190, 1'b1);
        req(274, 190, 1'b0);
        idle(2);
        check("collision_addr_after", rom_addr, 1);

        // move_en low across three frames: position holds, counter clears
        for (int f = 0; f < 3; f++) begin
            req(270, 190, 1'b0);
            req(271, 190, 1'b0);
            idle(1);
            fs_pulse();
            check("hold_addr_cleared", rom_addr, 0);
            check("hold_pic_x", pic_x, 270);
            check("hold_pic_y", pic_y, 190);
        end

        // bounce sequence with hand-computed positions
        move_en = 1'b1;
        for (int i = 1; i <= 571; i++) begin
            fs_pulse();
            if (i == 269) begin
                check("b269_x", pic_x, 539);
                check("b269_y", pic_y, 301);
                check("b269_dir_x", dut.u_axis_x.dir, FWD);
            end
            if (i == 270) begin
                check("b270_x", pic_x, 540);
                check("b270_dir_x", dut.u_axis_x.dir, FWD);
                check("b270_y", pic_y, 300);
            end
            if (i == 271) begin
                check("b271_x", pic_x, 539);
                check("b271_dir_x", dut.u_axis_x.dir, REV);
                check("b271_y", pic_y, 299);
            end
            if (i == 570) begin
                check("b570_y", pic_y, 0);
                check("b570_dir_y", dut.u_axis_y.dir, REV);
                check("b570_x", pic_x, 240);
            end
            if (i == 571) begin
                check("b571_y", pic_y, 1);
                check("b571_dir_y", dut.u_axis_y.dir, FWD);
                check("b571_x", pic_x, 239);
                check("b571_dir_x", dut.u_axis_x.dir, REV);
            end
        end
        move_en = 1'b0;

        // reads at the moved position, then reset mid-frame
        mpx = 239; mpy = 1;
        fs_pulse();
        req(238, 1, 1'b0);
        req(239, 1, 1'b0);
        req(240, 1, 1'b0);
        req(241, 1, 1'b0);
        idle(3);
        check("moved_addr", rom_addr, 3);
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        check("mrst_pic_x", pic_x, 270);
        check("mrst_pic_y", pic_y, 190);
        check("mrst_addr", rom_addr, 0);
        check("mrst_dir_x", dut.u_axis_x.dir, FWD);
        check("mrst_dir_y", dut.u_axis_y.dir, FWD);
        check("mrst_pix_data", pix_data, 0);

        mpx = 270; mpy = 190;
        fs_pulse();
        rd0 = rd_count;
        scan_window(190, 289);
        check("frame2_rd_count", rd_count - rd0, 10000);

        idle(4);
        check("addr_q_drained", addr_q.size(), 0);
        check("pix_q_drained", pix_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
